// File: rtl/board_move_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : ttt_pkg                                                    |
// | Description : Shared tic-tac-toe types: cell encodings, arbiter states,  |
// |               winning-line table, default search order, cell lookup.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ttt_pkg;

  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] PLAYER   = 2'b01;
  localparam logic [1:0] COMPUTER = 2'b10;

  // Cell indices searched in nibble order, nibble 0 first: 4,0,2,6,8,1,3,5,7.
  localparam logic [35:0] DEFAULT_SCAN_PRIO = 36'h753186204;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_READY = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Three rows, three columns, two diagonals.
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Returns the content of one cell; out-of-range indices read as EMPTY so
  // callers never index past the board.
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] r;
    r = EMPTY;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) r = b[2*i +: 2];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_move_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : board_move_arbiter_if                                      |
// | Description : Player/computer move strobes plus board and status flags. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface board_move_arbiter_if;
  logic        player_play;
  logic [3:0]  player_pos;
  logic        computer_play;
  logic        illegal_move;
  logic        comp;
  logic [3:0]  comp_pos;
  logic        win;
  logic [1:0]  winner;
  logic        no_space;
  logic [17:0] board;

  // Game controller side: drives strobes, observes the board and flags.
  modport master (
    output player_play, player_pos, computer_play,
    input  illegal_move, comp, comp_pos, win, winner, no_space, board
  );

  // Arbiter side.
  modport slave (
    input  player_play, player_pos, computer_play,
    output illegal_move, comp, comp_pos, win, winner, no_space, board
  );
endinterface
`default_nettype wire

// File: rtl/board_move_arbiter_line_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ttt_line_check                                             |
// | Description : Flags whether any of the eight lines is fully owned by     |
// |               the given symbol on the given board.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board_i,
  input  logic [1:0]  sym_i,
  output logic        line_hit_o
);

  // Any line whose three cells all equal the symbol is a hit.
  always_comb begin
    line_hit_o = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if ((cell_of(board_i, WIN_LINES[k][0]) == sym_i) &&
          (cell_of(board_i, WIN_LINES[k][1]) == sym_i) &&
          (cell_of(board_i, WIN_LINES[k][2]) == sym_i)) begin
        line_hit_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_move_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : board_move_arbiter                                         |
// | Description : Owns the 3x3 board, takes player moves, searches and       |
// |               evaluates the computer reply and commits it on request.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module board_move_arbiter
  import ttt_pkg::*;
#(
  parameter logic [35:0] SCAN_PRIO = DEFAULT_SCAN_PRIO,
  parameter int          CELLS     = 9
)(
  input  logic                 clk,
  input  logic                 rst,
  board_move_arbiter_if.slave  bus
);

  state_t             state_q;
  logic [2*CELLS-1:0] board_q;
  logic [3:0]         idx_q;
  logic [3:0]         cand_q;
  logic               cand_v_q;
  logic               comp_q;
  logic [3:0]         comp_pos_q;
  logic               win_q;
  logic [1:0]         winner_q;
  logic               no_space_q;

  logic               w_illegal;
  logic [3:0]         w_scan_cell;
  logic [17:0]        w_cand_board;
  logic               w_p_hit;
  logic               w_c_hit;
  logic               w_cand_eff;
  logic               w_other_empty;

  // A request is rejected when busy, out of range, or aimed at a taken cell.
  assign w_illegal = bus.player_play &&
                     ((state_q != ST_IDLE) || (bus.player_pos > 4'd8) ||
                      (cell_of(board_q, bus.player_pos) != EMPTY));

  // A player line cancels the pending computer move.
  assign w_cand_eff = cand_v_q && !w_p_hit;

  // Select the cell currently being probed from the priority list.
  always_comb begin
    w_scan_cell = 4'hF;
    for (int i = 0; i < CELLS; i++) begin
      if (idx_q == 4'(i)) w_scan_cell = SCAN_PRIO[4*i +: 4];
    end
  end

  // Board as it would look with the candidate placed for the computer.
  always_comb begin
    w_cand_board = board_q;
    for (int i = 0; i < CELLS; i++) begin
      if (cand_v_q && (cand_q == 4'(i))) w_cand_board[2*i +: 2] = COMPUTER;
    end
  end

  // Any empty cell other than the move about to be played means space remains.
  always_comb begin
    w_other_empty = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if ((board_q[2*i +: 2] == EMPTY) && !(w_cand_eff && (cand_q == 4'(i))))
        w_other_empty = 1'b1;
    end
  end

  ttt_line_check u_player_lines (
    .board_i    (board_q),
    .sym_i      (PLAYER),
    .line_hit_o (w_p_hit)
  );

  ttt_line_check u_comp_lines (
    .board_i    (w_cand_board),
    .sym_i      (COMPUTER),
    .line_hit_o (w_c_hit)
  );

  // Move sequencing: player write, priority scan, lookahead, commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      board_q    <= '0;
      idx_q      <= 4'd0;
      cand_q     <= 4'd0;
      cand_v_q   <= 1'b0;
      comp_q     <= 1'b0;
      comp_pos_q <= 4'hF;
      win_q      <= 1'b0;
      winner_q   <= 2'b00;
      no_space_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.player_play && !w_illegal) begin
            for (int i = 0; i < CELLS; i++) begin
              if (bus.player_pos == 4'(i)) board_q[2*i +: 2] <= PLAYER;
            end
            idx_q   <= 4'd0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cell_of(board_q, w_scan_cell) == EMPTY) begin
            cand_q   <= w_scan_cell;
            cand_v_q <= 1'b1;
            state_q  <= ST_EVAL;
          end else if (idx_q == 4'(CELLS - 1)) begin
            cand_v_q <= 1'b0;
            state_q  <= ST_EVAL;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        ST_EVAL: begin
          if (w_p_hit) begin
            win_q    <= 1'b1;
            winner_q <= PLAYER;
            cand_v_q <= 1'b0;
          end else if (cand_v_q && w_c_hit) begin
            win_q    <= 1'b1;
            winner_q <= COMPUTER;
          end
          no_space_q <= !w_other_empty;
          comp_pos_q <= w_cand_eff ? cand_q : 4'hF;
          comp_q     <= 1'b1;
          state_q    <= ST_READY;
        end
        ST_READY: begin
          if (bus.computer_play) begin
            for (int i = 0; i < CELLS; i++) begin
              if (cand_v_q && (cand_q == 4'(i))) board_q[2*i +: 2] <= COMPUTER;
            end
            comp_q  <= 1'b0;
            state_q <= (win_q || no_space_q) ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          // Game over: everything is frozen until reset.
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.illegal_move = w_illegal;
  assign bus.comp         = comp_q;
  assign bus.comp_pos     = comp_pos_q;
  assign bus.win          = win_q;
  assign bus.winner       = winner_q;
  assign bus.no_space     = no_space_q;
  assign bus.board        = board_q;

endmodule
`default_nettype wire
